inert_burst_rdr: RTL
====================

// Module: inert_burst_rdr
// PURPOSE
// Parametrised successor of the inertial-sensor interface sequencer. Drives an external SPI
// master through a snd/cmd/done/resp handshake and runs three phases:
//  - power-up delay, then a programmable init command list;
//  - on each sensor interrupt, burst-reads NUM_CH 16-bit channels (low byte, then high byte).
// Publishes all channels atomically with a vld pulse. Adds continuous mode, INT watchdog and
// overrun detection. Sits between the SPI master and the inertial integrator.
// PARAMETERS
// NUM_CH      4                   number of 16-bit channels per burst (1..8)
// CH_ADDR     {8'h2C,8'h2A,8'h26,8'h24}  packed NUM_CH*8 low-byte reg addrs, ch0 in LSBs
// NUM_INIT    4                   number of init commands (1..8)
// INIT_CMDS   {16'h1460,16'h1150,16'h1053,16'h0D02}  packed NUM_INIT*16, cmd0 in LSBs
// PWRUP_BITS  16                  power-up counter width; init starts when counter all ones
// TO_BITS     20                  INT watchdog counter width
// PORTS
// clk        in   1             clock
// rst_n      in   1             async active-low reset
// INT        in   1             sensor data-ready, asynchronous; level-sensitive
// cont_mode  in   1             1 = start next burst right after vld, ignoring INT
// clr_flags  in   1             synchronous clear of ovr
// done       in   1             SPI master: 1-cycle pulse, transaction complete; resp valid that cycle
// resp       in   16            SPI master read data; low byte used
// snd        out  1             1-cycle pulse: start SPI transaction with cmd
// cmd        out  16            SPI command; held stable from snd until matching done
// data       out  NUM_CH*16     published channels; ch0 = data[15:0]
// vld        out  1             1-cycle pulse: data updated this cycle
// init_done  out  1             init list complete (sticky until reset)
// stale      out  1             no INT for 2^TO_BITS WAIT cycles
// ovr        out  1             sticky: INT rising edge seen during a burst
// BEHAVIOUR
// - Reset values: snd=0, cmd=0, data=0, vld=0, init_done=0, stale=0, ovr=0, state=PWRUP,
//   all counters 0.
// - INT is double-flopped. int_s is the 2nd flop; an int_s rise is int_s=1 with the prior int_s=0.
// - PWRUP: counter increments each cycle. When it reaches all ones: snd=1, cmd=INIT_CMDS[0],
//   go to INIT with idx=0.
// - INIT: on done, if idx<NUM_INIT-1 then idx++, snd=1 with the next command in the same cycle.
//   Otherwise init_done=1, go to WAIT.
// - WAIT: if int_s=1, or cont_mode=1 on the cycle after vld: snd=1, cmd={1'b1,CH_ADDR[0][6:0],8'h00},
//   byte idx b=0, go to READ.
// - READ: each done captures resp[7:0] into shadow byte b. Byte 2k = ch k low, byte 2k+1 = ch k high.
//   - If b<2*NUM_CH-1: b++ and snd=1 in the same cycle. Address = CH_ADDR[k] (+1 for a high byte).
//   - On the final done: data<=shadow (with this byte), vld=1, go to WAIT.
//   - Back-to-back throughput is one transaction per done. No idle cycle is inserted.
// - data changes only on vld cycles. A partial burst is never visible.
// - Watchdog: counts cycles in WAIT and clears on leaving WAIT. On reaching all ones: stale=1,
//   counter wraps to 0. stale clears on the next vld.
// - ovr: set by an int_s rise while in READ. Cleared by clr_flags. Set wins if both occur the same cycle.
// - A done in PWRUP or WAIT is ignored. snd is never asserted while a transaction is outstanding.
// - Reset mid-burst or mid-init abandons the transaction; the sequence restarts from PWRUP.
// - Latency, WAIT to vld: 2 (sync) + 1 + 2*NUM_CH SPI transactions.
// TESTING
// - Reset, PWRUP_BITS=4 -> first snd with cmd=16'h0D02 at cycle 15; 4 init cmds in order on each
//   done; then init_done=1.
// - INT high, SPI model returns bytes 8'h01..8'h08 -> cmds A4,A5,A6,A7,AA,AB,AC,AD (hi byte).
//   Then one vld with data={16'h0807,16'h0605,16'h0403,16'h0201}.
// - data checked before vld mid-burst -> still holds the previous burst (0 after reset).
// - INT toggles 0->1 during READ -> ovr=1 after the burst. clr_flags -> ovr=0; simultaneous
//   set+clr -> ovr=1.
// - TO_BITS=6, INT held low after init -> stale=1 after 64 WAIT cycles; next burst vld -> stale=0.
// - cont_mode=1, INT low -> new burst snd the cycle after vld. rst_n low mid-burst -> all outputs
//   return to reset values.

Source files
------------

// File: rtl/inert_burst_rdr.sv
// inert_burst_rdr: sequencer for an inertial sensor behind an SPI master.
// After a power-up delay it sends a fixed init command list. After that, each data-ready
// interrupt (or a continuous-mode restart) triggers a burst read of NUM_CH 16-bit channels.
// The channels are published together, with a one-cycle vld pulse.
// A watchdog flags a missing interrupt, and a sticky flag records interrupts that arrive mid-burst.
module inert_burst_rdr #(
    parameter int                     NUM_CH     = 4,
    parameter logic [NUM_CH*8-1:0]    CH_ADDR    = {8'h2C, 8'h2A, 8'h26, 8'h24},
    parameter int                     NUM_INIT   = 4,
    parameter logic [NUM_INIT*16-1:0] INIT_CMDS  = {16'h1460, 16'h1150, 16'h1053, 16'h0D02},
    parameter int                     PWRUP_BITS = 16,
    parameter int                     TO_BITS    = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 INT,
    input  logic                 cont_mode,
    input  logic                 clr_flags,
    input  logic                 done,
    input  logic [15:0]          resp,
    output logic                 snd,
    output logic [15:0]          cmd,
    output logic [NUM_CH*16-1:0] data,
    output logic                 vld,
    output logic                 init_done,
    output logic                 stale,
    output logic                 ovr
);

    localparam logic [2:0] INIT_LAST = 3'(NUM_INIT - 1);
    localparam logic [3:0] BYTE_LAST = 4'(2 * NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_PWRUP = 2'd0,
        ST_INIT  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [PWRUP_BITS-1:0]   pwr_cnt_q;
    logic [PWRUP_BITS-1:0]   pwr_cnt_d;
    logic [TO_BITS-1:0]      wd_cnt_q;
    logic [2:0]              idx_q;
    logic [3:0]              byte_q;
    logic [NUM_CH*16-1:0]    shadow_q;
    logic [NUM_CH*16-1:0]    shadow_d;
    logic [NUM_CH*16-1:0]    data_q;
    logic                    snd_q;
    logic [15:0]             cmd_q;
    logic                    vld_q;
    logic                    init_done_q;
    logic                    stale_q;
    logic                    ovr_q;
    logic                    int_meta_q;
    logic                    int_sync_q;
    logic                    int_prev_q;
    logic                    int_rise_s;
    logic                    start_s;
    logic [15:0]             init_next_cmd_s;
    logic                    resp_hi_unused_s;

    // Build the read command for burst byte b: high bit set, then the channel register address.
    // A high byte (odd b) uses the channel's low-byte address plus one.
    function automatic logic [15:0] rd_cmd(input logic [3:0] byte_idx);
        logic [6:0] reg_addr;
        reg_addr = CH_ADDR[8*int'(byte_idx[3:1]) +: 7] + {6'd0, byte_idx[0]};
        return {1'b1, reg_addr, 8'h00};
    endfunction

    // Only the low byte of the SPI read data carries register contents.
    assign resp_hi_unused_s = ^resp[15:8];

    assign int_rise_s      = int_sync_q & ~int_prev_q;
    assign start_s         = int_sync_q | (cont_mode & vld_q);
    assign pwr_cnt_d       = pwr_cnt_q + {{(PWRUP_BITS-1){1'b0}}, 1'b1};
    assign init_next_cmd_s = INIT_CMDS[16*(int'(idx_q) + 1) +: 16];

    // Merge the byte returned by the current transaction into its slot of the burst shadow.
    always_comb begin
        shadow_d = shadow_q;
        if ((state_q == ST_READ) && done) begin
            shadow_d[8*int'(byte_q) +: 8] = resp[7:0];
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Two-flop synchroniser for the asynchronous interrupt, plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
            int_prev_q <= 1'b0;
        end else begin
            int_meta_q <= INT;
            int_sync_q <= int_meta_q;
            int_prev_q <= int_sync_q;
        end
    end

    // Overrun flag: set by an interrupt edge during a burst. Set takes priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (int_rise_s && (state_q == ST_READ)) begin
            ovr_q <= 1'b1;
        end else if (clr_flags) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_q;
        end
    end

    // Main sequencer: power-up delay, init list, wait for trigger, burst read, and the watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PWRUP;
            pwr_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            idx_q       <= 3'd0;
            byte_q      <= 4'd0;
            shadow_q    <= '0;
            data_q      <= '0;
            snd_q       <= 1'b0;
            cmd_q       <= 16'h0000;
            vld_q       <= 1'b0;
            init_done_q <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            snd_q <= 1'b0;
            vld_q <= 1'b0;
            case (state_q)
                ST_PWRUP: begin
                    pwr_cnt_q <= pwr_cnt_d;
                    if (&pwr_cnt_d) begin
                        snd_q   <= 1'b1;
                        cmd_q   <= INIT_CMDS[15:0];
                        idx_q   <= 3'd0;
                        state_q <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (done) begin
                        if (idx_q != INIT_LAST) begin
                            idx_q <= idx_q + 3'd1;
                            snd_q <= 1'b1;
                            cmd_q <= init_next_cmd_s;
                        end else begin
                            init_done_q <= 1'b1;
                            wd_cnt_q    <= '0;
                            state_q     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (start_s) begin
                        snd_q    <= 1'b1;
                        cmd_q    <= rd_cmd(4'd0);
                        byte_q   <= 4'd0;
                        wd_cnt_q <= '0;
                        state_q  <= ST_READ;
                    end else if (&wd_cnt_q) begin
                        stale_q  <= 1'b1;
                        wd_cnt_q <= '0;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + {{(TO_BITS-1){1'b0}}, 1'b1};
                    end
                end
                ST_READ: begin
                    wd_cnt_q <= '0;
                    if (done) begin
                        shadow_q <= shadow_d;
                        if (byte_q != BYTE_LAST) begin
                            byte_q <= byte_q + 4'd1;
                            snd_q  <= 1'b1;
                            cmd_q  <= rd_cmd(byte_q + 4'd1);
                        end else begin
                            data_q  <= shadow_d;
                            vld_q   <= 1'b1;
                            stale_q <= 1'b0;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                default: begin
                    state_q <= ST_PWRUP;
                end
            endcase
        end
    end

    assign snd       = snd_q;
    assign cmd       = cmd_q;
    assign data      = data_q;
    assign vld       = vld_q;
    assign init_done = init_done_q;
    assign stale     = stale_q;
    assign ovr       = ovr_q;

endmodule
